// File: rtl/dram_arbiter.sv
// Two-client line arbiter (I-cache read-only, D-cache read/write) in front of one DRAM port.
// Round-robin on contention; a watchdog aborts transactions whose completion valid never arrives.
module dram_arbiter #(
    parameter int ByteOffsetBits = 5,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int LINE_SIZE     = 8 * (2 ** ByteOffsetBits)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ic_req_i,
    input  logic [31:0]          ic_add_i,
    output logic                 ic_done_o,
    output logic                 ic_err_o,
    output logic [LINE_SIZE-1:0] ic_data_o,
    input  logic                 dc_req_i,
    input  logic                 dc_we_i,
    input  logic [31:0]          dc_add_i,
    input  logic [LINE_SIZE-1:0] dc_data_i,
    output logic                 dc_done_o,
    output logic                 dc_err_o,
    output logic [LINE_SIZE-1:0] dc_data_o,
    output logic [31:0]          mem_add_o,
    output logic                 mem_read_enable_o,
    output logic                 mem_write_enable_o,
    output logic [LINE_SIZE-1:0] mem_data_o,
    input  logic                 mem_read_valid_i,
    input  logic                 mem_write_valid_i,
    input  logic [LINE_SIZE-1:0] mem_data_i
);
    // state | meaning
    // IDLE  | no transaction; arbitrate and latch the winner's request
    // READ  | read enable held, waiting for read valid or watchdog
    // WRITE | write enable held, waiting for write valid or watchdog
    // RESP  | one-cycle done/err to the granted client, enables low
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t r_state, w_state_nxt;

    logic                 r_gnt_d, w_gnt_d_nxt;
    logic                 r_last_d, w_last_d_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [31:0]          r_mem_add, w_mem_add_nxt;
    logic                 r_rd_en, w_rd_en_nxt;
    logic                 r_wr_en, w_wr_en_nxt;
    logic [LINE_SIZE-1:0] r_mem_data, w_mem_data_nxt;
    logic [LINE_SIZE-1:0] r_ic_data, w_ic_data_nxt;
    logic [LINE_SIZE-1:0] r_dc_data, w_dc_data_nxt;
    logic                 r_ic_done, w_ic_done_nxt;
    logic                 r_dc_done, w_dc_done_nxt;
    logic                 r_ic_err, w_ic_err_nxt;
    logic                 r_dc_err, w_dc_err_nxt;

    logic                 w_gnt_any, w_gnt_d, w_gnt_we, w_timeout;
    logic [LINE_SIZE-1:0] w_rd_line;

    // On a tie the client that did not win last time gets the port.
    always_comb begin
        w_gnt_any = ic_req_i | dc_req_i;
        if (ic_req_i && dc_req_i) begin
            w_gnt_d = ~r_last_d;
        end else begin
            w_gnt_d = dc_req_i;
        end
        w_gnt_we  = w_gnt_d & dc_we_i;
        w_timeout = (r_cnt == CNT_LAST);
        w_rd_line = mem_read_valid_i ? mem_data_i : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_gnt_any) w_state_nxt = w_gnt_we ? ST_WRITE : ST_READ;
            ST_READ:  if (mem_read_valid_i || w_timeout) w_state_nxt = ST_RESP;
            ST_WRITE: if (mem_write_valid_i || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_d_nxt    = r_gnt_d;
        w_last_d_nxt   = r_last_d;
        w_cnt_nxt      = r_cnt;
        w_mem_add_nxt  = r_mem_add;
        w_mem_data_nxt = r_mem_data;
        w_ic_data_nxt  = r_ic_data;
        w_dc_data_nxt  = r_dc_data;
        w_rd_en_nxt    = 1'b0;
        w_wr_en_nxt    = 1'b0;
        w_ic_done_nxt  = 1'b0;
        w_dc_done_nxt  = 1'b0;
        w_ic_err_nxt   = 1'b0;
        w_dc_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_any) begin
                    w_gnt_d_nxt    = w_gnt_d;
                    w_last_d_nxt   = w_gnt_d;
                    w_cnt_nxt      = '0;
                    w_mem_add_nxt  = w_gnt_d ? dc_add_i : ic_add_i;
                    w_mem_data_nxt = w_gnt_we ? dc_data_i : '0;
                    w_rd_en_nxt    = ~w_gnt_we;
                    w_wr_en_nxt    = w_gnt_we;
                end
            end
            ST_READ: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (mem_read_valid_i || w_timeout) begin
                    if (r_gnt_d) begin
                        w_dc_data_nxt = w_rd_line;
                        w_dc_done_nxt = 1'b1;
                        w_dc_err_nxt  = ~mem_read_valid_i;
                    end else begin
                        w_ic_data_nxt = w_rd_line;
                        w_ic_done_nxt = 1'b1;
                        w_ic_err_nxt  = ~mem_read_valid_i;
                    end
                end else begin
                    w_rd_en_nxt = 1'b1;
                end
            end
            ST_WRITE: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (mem_write_valid_i || w_timeout) begin
                    w_dc_data_nxt = '0;
                    w_dc_done_nxt = 1'b1;
                    w_dc_err_nxt  = ~mem_write_valid_i;
                end else begin
                    w_wr_en_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // last_grant resets to D so that the I-cache wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gnt_d    <= 1'b0;
            r_last_d   <= 1'b1;
            r_cnt      <= '0;
            r_mem_add  <= '0;
            r_mem_data <= '0;
            r_ic_data  <= '0;
            r_dc_data  <= '0;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_ic_done  <= 1'b0;
            r_dc_done  <= 1'b0;
            r_ic_err   <= 1'b0;
            r_dc_err   <= 1'b0;
        end else begin
            r_gnt_d    <= w_gnt_d_nxt;
            r_last_d   <= w_last_d_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mem_add  <= w_mem_add_nxt;
            r_mem_data <= w_mem_data_nxt;
            r_ic_data  <= w_ic_data_nxt;
            r_dc_data  <= w_dc_data_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_ic_done  <= w_ic_done_nxt;
            r_dc_done  <= w_dc_done_nxt;
            r_ic_err   <= w_ic_err_nxt;
            r_dc_err   <= w_dc_err_nxt;
        end
    end

    assign ic_done_o          = r_ic_done;
    assign ic_err_o           = r_ic_err;
    assign ic_data_o          = r_ic_data;
    assign dc_done_o          = r_dc_done;
    assign dc_err_o           = r_dc_err;
    assign dc_data_o          = r_dc_data;
    assign mem_add_o          = r_mem_add;
    assign mem_read_enable_o  = r_rd_en;
    assign mem_write_enable_o = r_wr_en;
    assign mem_data_o         = r_mem_data;

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter against a behavioural DRAM with fixed latency LAT.
module tb_dram_arbiter;
    localparam int LS  = 256;
    localparam int LAT = 10;
    localparam int TO  = 64;

    logic          clk, rst_n;
    logic          ic_req_i, ic_done_o, ic_err_o;
    logic [31:0]   ic_add_i;
    logic [LS-1:0] ic_data_o;
    logic          dc_req_i, dc_we_i, dc_done_o, dc_err_o;
    logic [31:0]   dc_add_i;
    logic [LS-1:0] dc_data_i, dc_data_o;
    logic [31:0]   mem_add_o;
    logic          mem_read_enable_o, mem_write_enable_o;
    logic [LS-1:0] mem_data_o, mem_data_i;
    logic          mem_read_valid_i, mem_write_valid_i;

    dram_arbiter #(.ByteOffsetBits(5), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ic_req_i(ic_req_i), .ic_add_i(ic_add_i), .ic_done_o(ic_done_o),
        .ic_err_o(ic_err_o), .ic_data_o(ic_data_o),
        .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_add_i(dc_add_i), .dc_data_i(dc_data_i),
        .dc_done_o(dc_done_o), .dc_err_o(dc_err_o), .dc_data_o(dc_data_o),
        .mem_add_o(mem_add_o), .mem_read_enable_o(mem_read_enable_o),
        .mem_write_enable_o(mem_write_enable_o), .mem_data_o(mem_data_o),
        .mem_read_valid_i(mem_read_valid_i), .mem_write_valid_i(mem_write_valid_i),
        .mem_data_i(mem_data_i)
    );

    typedef struct {
        logic          is_d;
        logic          err;
        logic [LS-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          m_e;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            m_cnt = 0;
    logic          tie0, spur;
    logic [LS-1:0] mem [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LS-1:0] init_line(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(i);
        return {8{w}};
    endfunction

    // DRAM: valid in the LAT+1-th cycle of a held enable.
    assign mem_read_valid_i  = (mem_read_enable_o && m_cnt == LAT && !tie0) || spur;
    assign mem_write_valid_i = (mem_write_enable_o && m_cnt == LAT && !tie0) || spur;
    assign mem_data_i        = mem[mem_add_o[8:5]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_read_enable_o || mem_write_enable_o) m_cnt <= m_cnt + 1;
        else m_cnt <= 0;
        if (mem_write_enable_o && mem_write_valid_i) mem[mem_add_o[8:5]] <= mem_data_o;
    end

    task automatic chk(input string name, input logic [LS-1:0] act, input logic [LS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic d, input logic err, input logic [LS-1:0] data, input int dl);
        exp_t e;
        e.is_d = d;
        e.err  = err;
        e.data = data;
        e.cyc  = cyc + dl;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (ic_done_o || dc_done_o) begin
            chk("done_exclusive", LS'(ic_done_o & dc_done_o), '0);
            chk("resp_enables_low", LS'({mem_read_enable_o, mem_write_enable_o}), '0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done ic=%b dc=%b cycle=%0d", ic_done_o, dc_done_o, cyc);
            end else begin
                m_e = sb_q.pop_front();
                chk("done_client", LS'(dc_done_o), LS'(m_e.is_d));
                chk("done_err", LS'(dc_done_o ? dc_err_o : ic_err_o), LS'(m_e.err));
                chk("done_data", dc_done_o ? dc_data_o : ic_data_o, m_e.data);
                chk("done_cycle", LS'(cyc), LS'(m_e.cyc));
            end
        end
    end

    task automatic run_ic(input logic [31:0] a);
        int k;
        ic_add_i = a;
        ic_req_i = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!ic_done_o && k < 200);
        if (!ic_done_o) begin
            checks++;
            errors++;
            $display("FAIL ic_done_wait no done within %0d cycles addr=%h", k, a);
        end
        ic_req_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_dc(input logic we, input logic [31:0] a, input logic [LS-1:0] d);
        int k;
        dc_we_i   = we;
        dc_add_i  = a;
        dc_data_i = d;
        dc_req_i  = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!dc_done_o && k < 200);
        if (!dc_done_o) begin
            checks++;
            errors++;
            $display("FAIL dc_done_wait no done within %0d cycles addr=%h", k, a);
        end
        dc_req_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = init_line(i);
        rst_n = 1'b0;
        tie0 = 1'b0;
        spur = 1'b0;
        ic_req_i = 1'b0;
        ic_add_i = '0;
        dc_req_i = 1'b0;
        dc_we_i = 1'b0;
        dc_add_i = '0;
        dc_data_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_ic_done", LS'(ic_done_o), '0);
        chk("rst_ic_err", LS'(ic_err_o), '0);
        chk("rst_ic_data", ic_data_o, '0);
        chk("rst_dc_done", LS'(dc_done_o), '0);
        chk("rst_dc_err", LS'(dc_err_o), '0);
        chk("rst_dc_data", dc_data_o, '0);
        chk("rst_mem_add", LS'(mem_add_o), '0);
        chk("rst_rd_en", LS'(mem_read_enable_o), '0);
        chk("rst_wr_en", LS'(mem_write_enable_o), '0);
        chk("rst_mem_data", mem_data_o, '0);
        rst_n = 1'b1;
        @(negedge clk);

        push(1'b0, 1'b0, init_line(2), 12);
        run_ic(32'h40);

        push(1'b1, 1'b0, '0, 12);
        run_dc(1'b1, 32'h20, {32{8'hA5}});
        push(1'b1, 1'b0, {32{8'hA5}}, 12);
        run_dc(1'b0, 32'h20, '0);

        push(1'b0, 1'b0, init_line(3), 12);
        push(1'b1, 1'b0, init_line(4), 25);
        fork
            run_ic(32'h60);
            run_dc(1'b0, 32'h80, '0);
        join
        push(1'b0, 1'b0, init_line(5), 12);
        push(1'b1, 1'b0, '0, 25);
        fork
            run_ic(32'hA0);
            run_dc(1'b1, 32'hC0, {32{8'h3C}});
        join

        // I served last, so the next tie goes to D.
        push(1'b0, 1'b0, init_line(2), 12);
        run_ic(32'h40);
        push(1'b1, 1'b0, {32{8'h3C}}, 12);
        push(1'b0, 1'b0, init_line(8), 25);
        fork
            run_ic(32'h100);
            run_dc(1'b0, 32'hC0, '0);
        join

        tie0 = 1'b1;
        push(1'b0, 1'b1, '0, TO + 1);
        run_ic(32'h60);
        push(1'b1, 1'b1, '0, TO + 1);
        run_dc(1'b1, 32'h40, {32{8'hFF}});
        tie0 = 1'b0;
        push(1'b0, 1'b0, init_line(3), 12);
        run_ic(32'h60);

        ic_add_i = 32'h80;
        ic_req_i = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_rd_en", LS'(mem_read_enable_o), LS'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_rd_en", LS'(mem_read_enable_o), '0);
        chk("async_rst_wr_en", LS'(mem_write_enable_o), '0);
        chk("async_rst_ic_data", ic_data_o, '0);
        ic_req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(1'b0, 1'b0, init_line(2), 12);
        run_ic(32'h40);

        spur = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("spurious_valid_enables", LS'({mem_read_enable_o, mem_write_enable_o}), '0);
        end
        spur = 1'b0;
        @(negedge clk);
        push(1'b1, 1'b0, {32{8'hA5}}, 12);
        run_dc(1'b0, 32'h20, '0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", LS'(sb_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
